// File: rtl/rate_stim_counter.sv
// rate_stim_counter
//   Rate-selectable stimulus counter for MA7 devboard debug. A shared
//   prescaler produces count events at one of four divisors (DIV0..DIV3,
//   picked at run time by rateSel). On each event a WIDTH-bit counter steps
//   up or down, wrapping or saturating at its bounds. While paused, a rising
//   edge on step gives a single event. load takes priority over any event.
//
//   Optional build macro RATE_STIM_COUNTER_BCD_EN: value counts as packed
//   BCD (WIDTH/4 digits, MAX = all nines, load nibbles clamped to 9).
//   Without it, plain binary counting and loadValue is taken verbatim.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-low reset
//   enable     1 = free-run on prescaler events, 0 = paused (step active)
//   rateSel    selects DIV0..DIV3
//   dir        0 = count up, 1 = count down
//   satMode    0 = wrap at bounds, 1 = saturate at bounds
//   step       level input; rising edge gives one event while enable=0
//   load       load loadValue on the next edge
//   loadValue  load data
//   value      counter value (registered)
//   tick       one-cycle pulse when a counted value is first shown
//   wrapPulse  one-cycle pulse alongside tick when the count wrapped
//   limitHit   high while an event has been blocked by saturation
module rate_stim_counter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIV0  = 33554432,
    parameter int unsigned DIV1  = 4194304,
    parameter int unsigned DIV2  = 131072,
    parameter int unsigned DIV3  = 2048
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       rateSel,
    input  logic             dir,
    input  logic             satMode,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic [WIDTH-1:0] value,
    output logic             tick,
    output logic             wrapPulse,
    output logic             limitHit
);

    localparam int unsigned DIV_MAX01 = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int unsigned DIV_MAX23 = (DIV2 > DIV3) ? DIV2 : DIV3;
    localparam int unsigned DIV_MAX   = (DIV_MAX01 > DIV_MAX23) ? DIV_MAX01 : DIV_MAX23;
    localparam int unsigned PRE_W     = $clog2(DIV_MAX);

`ifdef RATE_STIM_COUNTER_BCD_EN
    localparam logic [WIDTH-1:0] MAX_VAL = {(WIDTH/4){4'h9}};

    if ((WIDTH % 4) != 0) begin : gBadWidth
        $error("rate_stim_counter: WIDTH must be a multiple of 4 in BCD mode");
    end

    function automatic logic [WIDTH-1:0] bcdInc(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < WIDTH / 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] bcdDec(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < WIDTH / 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] bcdClamp(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        for (int unsigned i = 0; i < WIDTH / 4; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction
`else
    localparam logic [WIDTH-1:0] MAX_VAL = '1;
`endif

    logic [PRE_W-1:0] prescaler, prescalerNext, termCount;
    logic [1:0]       rateSelQ;
    logic             stepQ;
    logic             preEvent, stepEvent, countEvent;
    logic             atBound;
    logic [WIDTH-1:0] steppedValue, loadData;

    always_comb begin
        termCount = PRE_W'(DIV0 - 1);
        case (rateSel)
            2'd0:    termCount = PRE_W'(DIV0 - 1);
            2'd1:    termCount = PRE_W'(DIV1 - 1);
            2'd2:    termCount = PRE_W'(DIV2 - 1);
            default: termCount = PRE_W'(DIV3 - 1);
        endcase
    end

    // A rate change restarts the prescaler and swallows any event that
    // cycle, so the next event lands a full new period after the change.
    always_comb begin
        prescalerNext = prescaler;
        preEvent      = 1'b0;
        if (!enable || (rateSel != rateSelQ)) begin
            prescalerNext = '0;
        end else if (prescaler == termCount) begin
            prescalerNext = '0;
            preEvent      = 1'b1;
        end else begin
            prescalerNext = prescaler + 1'b1;
        end
    end

    always_comb begin
        stepEvent  = step & ~stepQ & ~enable;
        countEvent = preEvent | stepEvent;
        atBound    = dir ? (value == '0) : (value == MAX_VAL);
`ifdef RATE_STIM_COUNTER_BCD_EN
        steppedValue = dir ? bcdDec(value) : bcdInc(value);
        loadData     = bcdClamp(loadValue);
`else
        steppedValue = dir ? (value - WIDTH'(1)) : (value + WIDTH'(1));
        loadData     = loadValue;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prescaler <= '0;
            rateSelQ  <= '0;
            stepQ     <= 1'b0;
            value     <= '0;
            tick      <= 1'b0;
            wrapPulse <= 1'b0;
            limitHit  <= 1'b0;
        end else begin
            prescaler <= prescalerNext;
            rateSelQ  <= rateSel;
            stepQ     <= step;
            tick      <= 1'b0;
            wrapPulse <= 1'b0;
            if (load) begin
                value    <= loadData;
                limitHit <= 1'b0;
            end else if (countEvent) begin
                if (atBound && satMode) begin
                    limitHit <= 1'b1;
                end else begin
                    value     <= steppedValue;
                    tick      <= 1'b1;
                    wrapPulse <= atBound;
                    limitHit  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rate_stim_counter.sv
// tb_rate_stim_counter
//   Directed bench for rate_stim_counter with WIDTH=8 and small divisors
//   (DIV0..DIV3 = 8,6,5,4). Binary-only vectors are used in the default
//   build; BCD vectors replace them when RATE_STIM_COUNTER_BCD_EN is defined.
module tb_rate_stim_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] rateSel;
    logic       dir;
    logic       satMode;
    logic       step;
    logic       load;
    logic [7:0] loadValue;
    logic [7:0] value;
    logic       tick;
    logic       wrapPulse;
    logic       limitHit;

    int checks = 0;
    int passed = 0;

    rate_stim_counter #(
        .WIDTH(8),
        .DIV0 (8),
        .DIV1 (6),
        .DIV2 (5),
        .DIV3 (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .rateSel  (rateSel),
        .dir      (dir),
        .satMode  (satMode),
        .step     (step),
        .load     (load),
        .loadValue(loadValue),
        .value    (value),
        .tick     (tick),
        .wrapPulse(wrapPulse),
        .limitHit (limitHit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    // Advance one edge; sample and drive 1 time unit after it.
    task automatic tickClk();
        @(posedge clk);
        #1;
    endtask

    task automatic doLoad(input logic [7:0] v);
        load      = 1'b1;
        loadValue = v;
        tickClk();
        load = 1'b0;
    endtask

    // Raise step for exactly one sampled edge, then release for one edge.
    task automatic stepHigh();
        step = 1'b1;
        tickClk();
    endtask

    task automatic stepLow();
        step = 1'b0;
        tickClk();
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        rateSel   = 2'd3;
        dir       = 1'b0;
        satMode   = 1'b0;
        step      = 1'b0;
        load      = 1'b0;
        loadValue = '0;
        tickClk();
        tickClk();
        check("rst_value", 32'(value), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_wrap", 32'(wrapPulse), 32'h0);
        check("rst_limit", 32'(limitHit), 32'h0);

        // Let rateSelQ settle to 3 before enabling.
        reset = 1'b1;
        tickClk();

        // Free-run at DIV3=4: value 1,2,3 at cycles 4,8,12.
        enable = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tickClk();
            if (c == 3) check("fr_before_first", 32'(value), 32'h0);
            if (c == 4 || c == 8 || c == 12) begin
                check("fr_value", 32'(value), 32'(c / 4));
                check("fr_tick", 32'(tick), 32'h1);
            end
            if (c == 5) check("fr_tick_low", 32'(tick), 32'h0);
        end

        // Rate change mid-count to DIV2=5.
        tickClk();
        tickClk();
        tickClk();
        rateSel = 2'd2;
        tickClk();
        check("rc_change_cycle", 32'(tick), 32'h0);
        for (int c = 1; c <= 4; c++) tickClk();
        check("rc_not_yet", 32'(value), 32'h3);
        tickClk();
        check("rc_first_event", 32'(value), 32'h4);
        check("rc_first_tick", 32'(tick), 32'h1);
        for (int c = 1; c <= 5; c++) tickClk();
        check("rc_period", 32'(value), 32'h5);

        // load coinciding with an event: load wins, no tick.
        for (int c = 1; c <= 4; c++) tickClk();
        doLoad(8'h42);
        check("ld_evt_value", 32'(value), 32'h42);
        check("ld_evt_tick", 32'(tick), 32'h0);
        for (int c = 1; c <= 5; c++) tickClk();
        check("ld_evt_next", 32'(value), 32'h43);

        enable = 1'b0;
        tickClk();

`ifndef RATE_STIM_COUNTER_BCD_EN
        // Up wrap.
        doLoad(8'hFE);
        stepHigh();
        check("wrap_ff", 32'(value), 32'hFF);
        check("wrap_ff_pulse", 32'(wrapPulse), 32'h0);
        stepLow();
        stepHigh();
        check("wrap_00", 32'(value), 32'h00);
        check("wrap_00_pulse", 32'(wrapPulse), 32'h1);
        check("wrap_00_tick", 32'(tick), 32'h1);
        stepLow();
        check("wrap_pulse_end", 32'(wrapPulse), 32'h0);

        // Up saturate.
        satMode = 1'b1;
        doLoad(8'hFE);
        stepHigh();
        stepLow();
        check("sat_ff", 32'(value), 32'hFF);
        stepHigh();
        check("sat_hold", 32'(value), 32'hFF);
        check("sat_limit", 32'(limitHit), 32'h1);
        check("sat_tick", 32'(tick), 32'h0);
        check("sat_wrap", 32'(wrapPulse), 32'h0);
        stepLow();
        check("sat_limit_holds", 32'(limitHit), 32'h1);
        doLoad(8'h00);
        check("sat_limit_clr", 32'(limitHit), 32'h0);

        // Down wrap via single step, then step held high.
        satMode = 1'b0;
        dir     = 1'b1;
        stepHigh();
        check("down_ff", 32'(value), 32'hFF);
        check("down_wrap", 32'(wrapPulse), 32'h1);
        for (int c = 1; c <= 9; c++) tickClk();
        check("step_held_value", 32'(value), 32'hFF);
        check("step_held_tick", 32'(tick), 32'h0);
        stepLow();

        // Down saturate at zero.
        satMode = 1'b1;
        doLoad(8'h00);
        stepHigh();
        check("dsat_value", 32'(value), 32'h00);
        check("dsat_limit", 32'(limitHit), 32'h1);
        stepLow();
`else
        doLoad(8'h09);
        stepHigh();
        check("bcd_09_up", 32'(value), 32'h10);
        stepLow();
        doLoad(8'h99);
        stepHigh();
        check("bcd_99_up", 32'(value), 32'h00);
        check("bcd_99_wrap", 32'(wrapPulse), 32'h1);
        stepLow();
        dir = 1'b1;
        doLoad(8'h10);
        stepHigh();
        check("bcd_10_down", 32'(value), 32'h09);
        stepLow();
        doLoad(8'hAF);
        check("bcd_clamp", 32'(value), 32'h99);
`endif

        // Reset mid-run with tick high.
        dir     = 1'b0;
        satMode = 1'b0;
        doLoad(8'h55);
        stepHigh();
        check("pre_rst_value", 32'(value), 32'h56);
        check("pre_rst_tick", 32'(tick), 32'h1);
        reset = 1'b0;
        tickClk();
        check("mid_rst_value", 32'(value), 32'h0);
        check("mid_rst_tick", 32'(tick), 32'h0);
        check("mid_rst_wrap", 32'(wrapPulse), 32'h0);
        check("mid_rst_limit", 32'(limitHit), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
